// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if
// One SRAM-like channel. The arbiter uses three instances: the instruction
// and data channels on the CPU side, and the shared memory port.
//
// Signals:
//   req, wr, size, addr, wdata  request fields (driven by the requester)
//   addr_ok                     address-phase acceptance (driven by the responder)
//   data_ok, rdata              data-phase return (driven by the responder)
//
// Modports:
//   master  the requester side (drives the request fields)
//   slave   the responder side (drives the handshakes and read data)

interface sram_like_arbiter_if;

   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output addr_ok, data_ok, rdata
   );

endinterface

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
// Two-to-one arbiter between the instruction-fetch and data SRAM-like
// channels and one shared SRAM-like port. One requester is granted per
// address phase, and the grant is held until addr_ok. The owner of every
// accepted transaction goes into an in-order FIFO, and each returning
// data_ok/rdata is routed to that owner.
//
// Parameters:
//   MAX_OUTSTANDING  accepted-but-not-returned limit (1..4), owner FIFO depth
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous active-high reset
//   inst          instruction channel (slave side of the CPU's request)
//   data          data channel (slave side of the CPU's request)
//   mem           shared port toward memory / the AXI bridge (master side)
//   err_spurious  sticky flag: mem data_ok arrived with no outstanding owner
//
// Optional feature:
//   ARB_ROUND_ROBIN_EN  when defined, contention alternates between masters
//                       through a last_grant register. When undefined, data
//                       always wins over inst.

module sram_like_arbiter #(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   sram_like_arbiter_if.slave    inst,
   sram_like_arbiter_if.slave    data,
   sram_like_arbiter_if.master   mem,
   output logic                  err_spurious
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int SLOTS = 1 << PTR_W;

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

   // Owner encoding: 0 = inst, 1 = data.
   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   typedef enum logic {
      LOCK_OPEN,
      LOCK_HELD
   } lockState_t;

   lockState_t        lockState_q, lockState_d;
   logic              grantSel_q, grantSel_d;
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              errSpurious_q, errSpurious_d;

   // The storage is rounded up to a power of two so that every pointer value
   // indexes a real entry. Pointers still wrap at MAX_OUTSTANDING, so the
   // extra entries are never used when the depth is not a power of two.
   logic [SLOTS-1:0]  ownerFifo_q;

   logic              grantSel;
   logic              selReq;
   logic              fifoEmpty;
   logic              fifoFull;
   logic              push;
   logic              pop;
   logic              headOwner;

`ifdef ARB_ROUND_ROBIN_EN
   logic              lastGrant_q, lastGrant_d;
`endif

   assign fifoEmpty = (count_q == '0);
   assign fifoFull  = (count_q == FULL_CNT);
   assign headOwner = ownerFifo_q[rdPtr_q];
   assign pop       = mem.data_ok && !fifoEmpty;
   assign push      = mem.req && mem.addr_ok;

   // Grant selection. While locked, the registered grant is reused, so the
   // request fields on mem stay stable until addr_ok. When nobody is
   // requesting, the previous grant is kept; mem.req is low in that case anyway.
   always_comb begin
      grantSel = grantSel_q;
      if (lockState_q == LOCK_HELD) begin
         grantSel = grantSel_q;
      end else if (inst.req && data.req) begin
`ifdef ARB_ROUND_ROBIN_EN
         grantSel = ~lastGrant_q;
`else
         grantSel = OWNER_DATA;
`endif
      end else if (data.req) begin
         grantSel = OWNER_DATA;
      end else if (inst.req) begin
         grantSel = OWNER_INST;
      end
   end

   // Shared port request mux and address-phase routing. A full FIFO blocks
   // issue unless a return in the same cycle frees the slot.
   always_comb begin
      selReq       = (grantSel == OWNER_DATA) ? data.req : inst.req;
      mem.req      = selReq && (!fifoFull || mem.data_ok);
      mem.wr       = (grantSel == OWNER_DATA) ? data.wr    : inst.wr;
      mem.size     = (grantSel == OWNER_DATA) ? data.size  : inst.size;
      mem.addr     = (grantSel == OWNER_DATA) ? data.addr  : inst.addr;
      mem.wdata    = (grantSel == OWNER_DATA) ? data.wdata : inst.wdata;
      inst.addr_ok = push && (grantSel == OWNER_INST);
      data.addr_ok = push && (grantSel == OWNER_DATA);
   end

   // Data-phase routing. Only the registered FIFO head decides the target,
   // so a return in the same cycle as an addr_ok goes to the older owner.
   // Read data is broadcast, and data_ok qualifies it.
   always_comb begin
      inst.data_ok = pop && (headOwner == OWNER_INST);
      data.data_ok = pop && (headOwner == OWNER_DATA);
      inst.rdata   = mem.rdata;
      data.rdata   = mem.rdata;
   end

   assign err_spurious = errSpurious_q;

   // Lock FSM. The lock is taken whenever a request is presented but not
   // accepted, and released by the acceptance.
   always_comb begin
      lockState_d = lockState_q;
      case (lockState_q)
         LOCK_OPEN: if (mem.req && !mem.addr_ok) lockState_d = LOCK_HELD;
         LOCK_HELD: if (mem.addr_ok)             lockState_d = LOCK_OPEN;
         default:                                lockState_d = LOCK_OPEN;
      endcase
   end

   // Next state for the grant, the FIFO pointers and count, and the sticky
   // error flag. A push and a pop in the same cycle leave the count unchanged.
   always_comb begin
      grantSel_d    = grantSel;
      wrPtr_d       = wrPtr_q;
      rdPtr_d       = rdPtr_q;
      count_d       = count_q;
      errSpurious_d = errSpurious_q;

      if (push) begin
         wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
      end
      if (pop) begin
         rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (mem.data_ok && fifoEmpty) begin
         errSpurious_d = 1'b1;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Remember the winner of every address handshake, so the other master
   // wins the next contention.
   always_comb begin
      lastGrant_d = lastGrant_q;
      if (push) lastGrant_d = grantSel;
   end
`endif

   // State registers. A reset discards any lock and any outstanding owners.
   always_ff @(posedge clk) begin
      if (reset) begin
         lockState_q   <= LOCK_OPEN;
         grantSel_q    <= OWNER_INST;
         wrPtr_q       <= '0;
         rdPtr_q       <= '0;
         count_q       <= '0;
         errSpurious_q <= 1'b0;
         ownerFifo_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         lastGrant_q   <= 1'b0;
`endif
      end else begin
         lockState_q   <= lockState_d;
         grantSel_q    <= grantSel_d;
         wrPtr_q       <= wrPtr_d;
         rdPtr_q       <= rdPtr_d;
         count_q       <= count_d;
         errSpurious_q <= errSpurious_d;
         if (push) begin
            ownerFifo_q[wrPtr_q] <= grantSel;
         end
`ifdef ARB_ROUND_ROBIN_EN
         lastGrant_q   <= lastGrant_d;
`endif
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter
// Directed testbench for sram_like_arbiter with MAX_OUTSTANDING = 2.
// Inputs change 1 time unit after the rising edge. Outputs are compared
// on the falling edge against hand-computed values.
// Flag vectors are packed as {inst.addr_ok, inst.data_ok, data.addr_ok,
// data.data_ok, mem.req}.

module tb_sram_like_arbiter;

   logic clk;
   logic reset;
   logic errSpurious;

   int testCount = 0;
   int failCount = 0;

   sram_like_arbiter_if instIf ();
   sram_like_arbiter_if dataIf ();
   sram_like_arbiter_if memIf ();

   sram_like_arbiter #(
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .inst         (instIf),
      .data         (dataIf),
      .mem          (memIf),
      .err_spurious (errSpurious)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Moves to the next cycle, applies the common inputs just after the edge,
   // then waits for the falling edge, where the outputs are compared.
   task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                                input logic dReq, input logic [31:0] dAddr,
                                input logic aOk, input logic dOk,
                                input logic [31:0] rd);
      @(posedge clk);
      #1;
      instIf.req    = iReq;
      instIf.addr   = iAddr;
      dataIf.req    = dReq;
      dataIf.addr   = dAddr;
      memIf.addr_ok = aOk;
      memIf.data_ok = dOk;
      memIf.rdata   = rd;
      @(negedge clk);
   endtask

   // Counts one comparison and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Compares all handshake outputs at once.
   task automatic checkFlags(input string tag, input logic [4:0] expected);
      checkOutput(tag,
                  {27'd0, instIf.addr_ok, instIf.data_ok, dataIf.addr_ok,
                   dataIf.data_ok, memIf.req},
                  {27'd0, expected});
   endtask

   initial begin
      reset         = 1'b1;
      instIf.req    = 1'b0;
      instIf.wr     = 1'b0;
      instIf.size   = 2'b10;
      instIf.addr   = 32'h0;
      instIf.wdata  = 32'h0;
      dataIf.req    = 1'b0;
      dataIf.wr     = 1'b0;
      dataIf.size   = 2'b01;
      dataIf.addr   = 32'h0;
      dataIf.wdata  = 32'h0;
      memIf.addr_ok = 1'b0;
      memIf.data_ok = 1'b0;
      memIf.rdata   = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkFlags("reset_flags", 5'b00000);
      checkOutput("reset_err", {31'd0, errSpurious}, 32'd0);

      // Single inst read, addr_ok on the 4th request cycle, data 2 cycles later.
      applyStimulus(1, 32'hBFC00000, 0, 32'h0, 0, 0, 32'h0);
      checkFlags("t1_wait0", 5'b00001);
      checkOutput("t1_addr", memIf.addr, 32'hBFC00000);
      checkOutput("t1_size", {30'd0, memIf.size}, 32'd2);
      applyStimulus(1, 32'hBFC00000, 0, 32'h0, 0, 0, 32'h0);
      checkFlags("t1_wait1", 5'b00001);
      applyStimulus(1, 32'hBFC00000, 0, 32'h0, 0, 0, 32'h0);
      checkFlags("t1_wait2", 5'b00001);
      applyStimulus(1, 32'hBFC00000, 0, 32'h0, 1, 0, 32'h0);
      checkFlags("t1_accept", 5'b10001);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
      checkFlags("t1_gap", 5'b00000);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h3C080001);
      checkFlags("t1_return", 5'b01000);
      checkOutput("t1_rdata", instIf.rdata, 32'h3C080001);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
      checkFlags("t1_idle", 5'b00000);

      // Pending inst keeps the grant while data arrives; data follows.
      applyStimulus(1, 32'h00001000, 0, 32'h0, 0, 0, 32'h0);
      checkOutput("t2_c1_addr", memIf.addr, 32'h00001000);
      applyStimulus(1, 32'h00001000, 1, 32'h00002000, 0, 0, 32'h0);
      checkOutput("t2_lock_addr", memIf.addr, 32'h00001000);
      checkFlags("t2_lock_flags", 5'b00001);
      applyStimulus(1, 32'h00001000, 1, 32'h00002000, 1, 0, 32'h0);
      checkFlags("t2_inst_acc", 5'b10001);
      checkOutput("t2_inst_addr", memIf.addr, 32'h00001000);
      applyStimulus(0, 32'h0, 1, 32'h00002000, 1, 0, 32'h0);
      checkFlags("t2_data_acc", 5'b00101);
      checkOutput("t2_data_addr", memIf.addr, 32'h00002000);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h11111111);
      checkFlags("t2_ret_inst", 5'b01000);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h22222222);
      checkFlags("t2_ret_data", 5'b00010);
      checkOutput("t2_rdata", dataIf.rdata, 32'h22222222);

      // Contention with addr_ok always high; the third cycle finds the FIFO full.
      applyStimulus(1, 32'h00003000, 1, 32'h00004000, 1, 0, 32'h0);
`ifdef ARB_ROUND_ROBIN_EN
      checkOutput("t3_c1_addr", memIf.addr, 32'h00003000);
`else
      checkOutput("t3_c1_addr", memIf.addr, 32'h00004000);
`endif
      applyStimulus(1, 32'h00003000, 1, 32'h00004000, 1, 0, 32'h0);
      checkOutput("t3_c2_addr", memIf.addr, 32'h00004000);
      applyStimulus(1, 32'h00003000, 1, 32'h00004000, 1, 0, 32'h0);
      checkFlags("t3_full", 5'b00000);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h0);
`ifdef ARB_ROUND_ROBIN_EN
      checkFlags("t3_ret1", 5'b01000);
`else
      checkFlags("t3_ret1", 5'b00010);
`endif
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h0);
      checkFlags("t3_ret2", 5'b00010);

      // Full FIFO; the third request issues in the same cycle as a return.
      applyStimulus(1, 32'h00005000, 0, 32'h0, 1, 0, 32'h0);
      checkFlags("t4_inst_acc", 5'b10001);
      dataIf.wr    = 1'b1;
      dataIf.wdata = 32'hDEADBEEF;
      applyStimulus(0, 32'h0, 1, 32'h00006000, 1, 0, 32'h0);
      checkFlags("t4_data_acc", 5'b00101);
      checkOutput("t4_wr", {31'd0, memIf.wr}, 32'd1);
      checkOutput("t4_wdata", memIf.wdata, 32'hDEADBEEF);
      checkOutput("t4_size", {30'd0, memIf.size}, 32'd1);
      dataIf.wr    = 1'b0;
      dataIf.wdata = 32'h0;
      applyStimulus(1, 32'h00007000, 0, 32'h0, 1, 0, 32'h0);
      checkFlags("t4_held", 5'b00000);
      applyStimulus(1, 32'h00007000, 0, 32'h0, 1, 1, 32'hA5A5A5A5);
      checkFlags("t4_pop_push", 5'b11001);
      checkOutput("t4_pop_rdata", instIf.rdata, 32'hA5A5A5A5);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h5A5A5A5A);
      checkFlags("t4_ret_data", 5'b00010);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h0);
      checkFlags("t4_ret_inst", 5'b01000);

      // Spurious return on an empty FIFO.
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h0);
      checkFlags("t5_drop", 5'b00000);
      checkOutput("t5_err_before", {31'd0, errSpurious}, 32'd0);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
      checkOutput("t5_err_set", {31'd0, errSpurious}, 32'd1);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
      checkOutput("t5_err_sticky", {31'd0, errSpurious}, 32'd1);

      // Reset with two transactions outstanding.
      applyStimulus(1, 32'h00008000, 0, 32'h0, 1, 0, 32'h0);
      checkFlags("t6_acc1", 5'b10001);
      applyStimulus(0, 32'h0, 1, 32'h00009000, 1, 0, 32'h0);
      checkFlags("t6_acc2", 5'b00101);
      @(posedge clk);
      #1;
      reset         = 1'b1;
      dataIf.req    = 1'b0;
      memIf.addr_ok = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkFlags("t6_after_reset", 5'b00000);
      checkOutput("t6_err_clear", {31'd0, errSpurious}, 32'd0);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h0);
      checkFlags("t6_stale_ret", 5'b00000);
      applyStimulus(1, 32'h0000A000, 0, 32'h0, 1, 0, 32'h0);
      checkOutput("t6_stale_err", {31'd0, errSpurious}, 32'd1);
      checkFlags("t6_resume", 5'b10001);
      checkOutput("t6_resume_addr", memIf.addr, 32'h0000A000);
      applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h12345678);
      checkFlags("t6_resume_ret", 5'b01000);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
